ssdisp_scan: RTL and testbench
==============================

SSDISP_SCAN -- requirements
Module: ssdisp_scan

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter NUM_DIGITS, default 8, SHALL set the number of scanned digits (legal 2..8).
REQ-003 Parameter PRESCALE, default 1000, SHALL set clk cycles per digit slot (legal >= 4).
REQ-004 Parameter GUARD, default 2, SHALL set blanked cycles at the start of each slot (legal 1..PRESCALE-2).
REQ-005 clk  input  1  system clock, rising edge.
REQ-006 nrst  input  1  asynchronous active-low reset.
REQ-007 enable  input  1  scan enable.
REQ-008 load_valid  input  1  new frame data offered.
REQ-009 load_data  input  4*NUM_DIGITS  hex nibble per digit; nibble i = bits [4i+3:4i] drives digit i.
REQ-010 load_mask  input  NUM_DIGITS  per-digit display enable.
REQ-011 load_dp  input  NUM_DIGITS  per-digit decimal point.
REQ-012 load_ready  output  1  shadow buffer free.
REQ-013 seg  output  8  active-high segments; bit7 = dp, bits 6:0 = g..a.
REQ-014 an  output  NUM_DIGITS  active-high one-hot digit select.
REQ-015 frame_done  output  1  single-cycle pulse at end of each full scan.

Function
REQ-016 FSM states SHALL be OFF, GUARD, DRIVE; OFF exits to GUARD with digit index 0 and prescale count 0 when enable is 1.
REQ-017 In GUARD, an and seg SHALL be all-zero; after GUARD cycles the FSM SHALL enter DRIVE.
REQ-018 In DRIVE, an SHALL have only bit idx set and seg SHALL hold the decoded current digit; after PRESCALE-GUARD cycles the FSM SHALL re-enter GUARD with idx advanced.
REQ-019 idx SHALL wrap from NUM_DIGITS-1 to 0; frame_done SHALL pulse for one cycle on the clock edge that performs that wrap.
REQ-020 Decode SHALL be 0..F -> 3F,06,5B,4F,66,6D,7D,07,7F,67,77,7C,39,5E,79,71 on bits 6:0; bit7 = dp bit of the digit.
REQ-021 A digit with mask bit 0 SHALL drive seg = 00 with its an bit still asserted.
REQ-022 A load handshake SHALL occur when load_valid and load_ready are both 1 on a clock edge; data, mask and dp are captured into the shadow buffer and load_ready falls on the next cycle.
REQ-023 The shadow SHALL copy into the active registers on the frame wrap edge; load_ready SHALL return to 1 the cycle after that copy.
REQ-024 While the FSM is in OFF, a handshake SHALL copy directly into both shadow and active registers; load_ready SHALL stay 1.
REQ-025 A handshake coinciding with the wrap edge SHALL be accepted into shadow only; the active registers SHALL take the previous shadow contents if pending, otherwise remain unchanged.
REQ-026 When enable drops, the FSM SHALL go to OFF on the next edge: an = 0, seg = 00, counters cleared, no frame_done, pending shadow retained.
REQ-027 Active data SHALL never change mid-frame (no tearing).

Reset
REQ-028 On nrst low: state OFF, idx 0, prescale count 0, active and shadow registers 0, pending 0, an 0, seg 00, frame_done 0, load_ready 1.
REQ-029 Reset asserted mid-frame SHALL discard pending shadow data; the first scan after release SHALL start at digit 0 with GUARD.

Configuration
REQ-030 With macro SSDISP_LZ_BLANK_EN defined, leading zero digits (from digit NUM_DIGITS-1 downward, stopping at the first non-zero nibble, digit 0 always shown) SHALL display seg = 00 except for the dp bit.
REQ-031 Without SSDISP_LZ_BLANK_EN, all enabled digits SHALL display their nibble, zeros included.

Verification
REQ-032 Reset, enable = 1, load 0x0123ABCD with mask FF and dp 00 while OFF -> digit 0 shows 5E, digit 7 shows 3F; an cycles 01,02,..,80; 2-cycle blanking per slot; frame_done every 8000 clks.
REQ-033 Load 0xFFFFFFFF mid-frame -> load_ready 0 until the wrap; seg stays at old values until the wrap, then 71 on all digits.
REQ-034 Mask 0x0F, dp 0x01, data 0x88888888 -> digits 0..3 show 7F, digit 0 shows FF, digits 4..7 show 00 with an still pulsing.
REQ-035 Handshake on the frame_done edge with a prior pending load -> previous load displayed in the next frame, new load displayed in the frame after.
REQ-036 nrst low at digit 5 DRIVE with a pending load -> an = 0, load_ready = 1; after release, scan restarts at digit 0 with the old pending data lost.
REQ-037 With SSDISP_LZ_BLANK_EN, data 0x00000400 -> digits 7..3 show 00, digit 2 shows 66, digits 1..0 show 3F; with data 0 -> only digit 0 shows 3F.

Source files
------------

// File: rtl/ssdisp_scan_if.sv
// Load-side handshake bundle for ssdisp_scan: one frame of hex nibbles,
// per-digit display enables and decimal points, with a valid/ready pair.
interface ssdisp_scan_if #(
   parameter int NUM_DIGITS = 8
);
   logic                    load_valid;
   logic [4*NUM_DIGITS-1:0] load_data;
   logic [NUM_DIGITS-1:0]   load_mask;
   logic [NUM_DIGITS-1:0]   load_dp;
   logic                    load_ready;

   modport master (output load_valid, load_data, load_mask, load_dp, input load_ready);
   modport slave  (input load_valid, load_data, load_mask, load_dp, output load_ready);
endinterface

// File: rtl/ssdisp_scan.sv
// Multiplexed seven-segment scanner with a double-buffered frame load.
// Define SSDISP_LZ_BLANK_EN to blank leading zero digits (dp still shown).
module ssdisp_scan #(
   parameter int NUM_DIGITS = 8,
   parameter int PRESCALE   = 1000,
   parameter int GUARD      = 2
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  enable,
   ssdisp_scan_if.slave          ld,
   output logic [7:0]            seg,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  frame_done
);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int CW = $clog2(PRESCALE);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0] LAST_CNT  = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] GUARD_END = CW'(GUARD - 1);

   typedef enum logic [1:0] {ST_OFF, ST_GUARD, ST_DRIVE} state_t;

   state_t                  r_state, w_state_next;
   logic [IW-1:0]           r_idx, w_idx_next;
   logic [CW-1:0]           r_cnt, w_cnt_next;
   logic                    r_frame_done;
   logic                    w_wrap;
   logic                    w_hs;
   logic [6:0]              w_seg7;
   logic [4*NUM_DIGITS-1:0] r_act_data, r_sh_data;
   logic [NUM_DIGITS-1:0]   r_act_mask, r_sh_mask;
   logic [NUM_DIGITS-1:0]   r_act_dp, r_sh_dp;
   logic                    r_pending;
   logic [3:0]              w_nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   w_lz;

   assign w_hs          = ld.load_valid & ~r_pending;
   assign ld.load_ready = ~r_pending;
   assign frame_done    = r_frame_done;

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign w_nib[gi] = r_act_data[4*gi +: 4];
   end

`ifdef SSDISP_LZ_BLANK_EN
   logic [NUM_DIGITS-1:0] w_nz;
   // A digit is a leading zero when it and every higher digit are zero.
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      assign w_nz[gi] = |r_act_data[4*gi +: 4];
      if (gi == 0) begin : g_first
         assign w_lz[gi] = 1'b0;
      end else begin : g_upper
         assign w_lz[gi] = ~|w_nz[NUM_DIGITS-1:gi];
      end
   end
`else
   assign w_lz = '0;
`endif

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state      <= ST_OFF;
         r_idx        <= '0;
         r_cnt        <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_idx        <= w_idx_next;
         r_cnt        <= w_cnt_next;
         r_frame_done <= w_wrap;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_cnt_next   = r_cnt;
      w_wrap       = 1'b0;
      if (!enable) begin
         w_state_next = ST_OFF;
         w_idx_next   = '0;
         w_cnt_next   = '0;
      end else begin
         case (r_state)
            ST_OFF: begin
               w_state_next = ST_GUARD;
               w_idx_next   = '0;
               w_cnt_next   = '0;
            end
            ST_GUARD: begin
               w_cnt_next = r_cnt + 1'b1;
               if (r_cnt == GUARD_END) w_state_next = ST_DRIVE;
            end
            ST_DRIVE: begin
               if (r_cnt == LAST_CNT) begin
                  w_state_next = ST_GUARD;
                  w_cnt_next   = '0;
                  if (r_idx == LAST_IDX) begin
                     w_idx_next = '0;
                     w_wrap     = 1'b1;
                  end else begin
                     w_idx_next = r_idx + 1'b1;
                  end
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
            default: w_state_next = ST_OFF;
         endcase
      end

      case (w_nib[r_idx])
         4'h0: w_seg7 = 7'h3F;  4'h1: w_seg7 = 7'h06;
         4'h2: w_seg7 = 7'h5B;  4'h3: w_seg7 = 7'h4F;
         4'h4: w_seg7 = 7'h66;  4'h5: w_seg7 = 7'h6D;
         4'h6: w_seg7 = 7'h7D;  4'h7: w_seg7 = 7'h07;
         4'h8: w_seg7 = 7'h7F;  4'h9: w_seg7 = 7'h67;
         4'hA: w_seg7 = 7'h77;  4'hB: w_seg7 = 7'h7C;
         4'hC: w_seg7 = 7'h39;  4'hD: w_seg7 = 7'h5E;
         4'hE: w_seg7 = 7'h79;  default: w_seg7 = 7'h71;
      endcase

      an  = '0;
      seg = 8'h00;
      if (r_state == ST_DRIVE) begin
         an = NUM_DIGITS'(1) << r_idx;
         if (r_act_mask[r_idx]) seg = {r_act_dp[r_idx], w_lz[r_idx] ? 7'h00 : w_seg7};
      end
   end

   // Active data only moves at the frame wrap (or freely while idle) so a frame never tears.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_act_data <= '0;
         r_act_mask <= '0;
         r_act_dp   <= '0;
         r_sh_data  <= '0;
         r_sh_mask  <= '0;
         r_sh_dp    <= '0;
         r_pending  <= 1'b0;
      end else if (r_state == ST_OFF) begin
         if (w_hs) begin
            r_act_data <= ld.load_data;
            r_act_mask <= ld.load_mask;
            r_act_dp   <= ld.load_dp;
            r_sh_data  <= ld.load_data;
            r_sh_mask  <= ld.load_mask;
            r_sh_dp    <= ld.load_dp;
         end
      end else begin
         if (w_wrap && r_pending) begin
            r_act_data <= r_sh_data;
            r_act_mask <= r_sh_mask;
            r_act_dp   <= r_sh_dp;
         end
         if (w_hs) begin
            r_sh_data <= ld.load_data;
            r_sh_mask <= ld.load_mask;
            r_sh_dp   <= ld.load_dp;
            r_pending <= 1'b1;
         end else if (w_wrap) begin
            r_pending <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_ssdisp_scan.sv
// Bench for ssdisp_scan: decode table, directed multi-cycle sequences and a
// randomized run checked every cycle against a slot-time reference model.
module tb_ssdisp_scan;
   localparam int ND    = 8;
   localparam int P     = 16;
   localparam int G     = 3;
   localparam int FRAME = ND * P;
   localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic          clk    = 1'b0;
   logic          nrst   = 1'b0;
   logic          enable = 1'b0;
   logic [7:0]    seg;
   logic [ND-1:0] an;
   logic          frame_done;

   ssdisp_scan_if #(.NUM_DIGITS(ND)) ld ();

   ssdisp_scan #(.NUM_DIGITS(ND), .PRESCALE(P), .GUARD(G)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .enable     (enable),
      .ld         (ld.slave),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference model: scan position is just the cycle count since enable, t in [0, FRAME).
   logic [31:0] m_ad = '0, m_sd = '0;
   logic [7:0]  m_am = '0, m_adp = '0, m_sm = '0, m_sdp = '0;
   bit          m_pend = 1'b0, m_on = 1'b0, m_fd = 1'b0;
   int          m_t = 0;

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         m_ad = '0; m_sd = '0; m_am = '0; m_adp = '0; m_sm = '0; m_sdp = '0;
         m_pend = 1'b0; m_on = 1'b0; m_fd = 1'b0; m_t = 0;
      end else begin
         bit hs, wrap;
         hs   = ld.load_valid && !m_pend;
         wrap = m_on && enable && (m_t == FRAME - 1);
         m_fd = wrap;
         if (!m_on) begin
            if (hs) begin
               m_ad = ld.load_data; m_am = ld.load_mask; m_adp = ld.load_dp;
               m_sd = ld.load_data; m_sm = ld.load_mask; m_sdp = ld.load_dp;
            end
         end else begin
            if (wrap && m_pend) begin
               m_ad = m_sd; m_am = m_sm; m_adp = m_sdp;
            end
            if (hs) begin
               m_sd = ld.load_data; m_sm = ld.load_mask; m_sdp = ld.load_dp;
               m_pend = 1'b1;
            end else if (wrap) begin
               m_pend = 1'b0;
            end
         end
         if (!enable) begin
            m_on = 1'b0; m_t = 0;
         end else if (!m_on) begin
            m_on = 1'b1; m_t = 0;
         end else begin
            m_t = (m_t + 1) % FRAME;
         end
      end
   end

   function automatic logic [ND-1:0] exp_an_f();
      if (!m_on || (m_t % P) < G) return '0;
      return ND'(1) << (m_t / P);
   endfunction

   function automatic logic [7:0] exp_seg_f();
      int slot;
`ifdef SSDISP_LZ_BLANK_EN
      int hi;
`endif
      if (!m_on || (m_t % P) < G) return 8'h00;
      slot = m_t / P;
      if (!m_am[slot]) return 8'h00;
`ifdef SSDISP_LZ_BLANK_EN
      hi = 0;
      for (int i = 0; i < ND; i++) if (m_ad[4*i +: 4] != 4'h0) hi = i;
      if (slot > hi) return {m_adp[slot], 7'h00};
`endif
      return {m_adp[slot], DEC[m_ad[4*slot +: 4]]};
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("an", 64'(an), 64'(exp_an_f()));
         check("seg", 64'(seg), 64'(exp_seg_f()));
         check("frame_done", 64'(frame_done), 64'(m_fd));
         check("load_ready", 64'(ld.load_ready), 64'(!m_pend));
      end
   end

   typedef struct {
      logic [31:0] data;
      logic [7:0]  mask;
      logic [7:0]  dp;
      logic [63:0] exp;
      logic [63:0] exp_lz;
   } vec_t;
   vec_t tbl [6];

   task automatic wait_fd(input string name, output int cycles);
      cycles = 0;
      do begin
         cyc(1);
         cycles++;
      end while (!frame_done && cycles < 2 * FRAME + 4);
      if (!frame_done) begin
         checks++;
         errors++;
         $display("FAIL %s timeout actual=no_pulse required=pulse", name);
      end
   endtask

   task automatic pulse_load(input logic [31:0] d, input logic [7:0] m, input logic [7:0] dp);
      ld.load_valid = 1'b1; ld.load_data = d; ld.load_mask = m; ld.load_dp = dp;
      cyc(1);
      ld.load_valid = 1'b0;
   endtask

   task automatic run_row(input int r);
      logic [63:0] e;
`ifdef SSDISP_LZ_BLANK_EN
      e = tbl[r].exp_lz;
`else
      e = tbl[r].exp;
`endif
      enable = 1'b0;
      cyc(2);
      pulse_load(tbl[r].data, tbl[r].mask, tbl[r].dp);
      check($sformatf("row%0d_ready_off", r), 64'(ld.load_ready), 64'd1);
      enable = 1'b1;
      cyc(1);
      check($sformatf("row%0d_guard_an", r), 64'(an), 64'd0);
      cyc(G);
      for (int d = 0; d < ND; d++) begin
         check($sformatf("row%0d_d%0d_an", r, d), 64'(an), 64'(ND'(1) << d));
         check($sformatf("row%0d_d%0d_seg", r, d), 64'(seg), 64'(e[8*d +: 8]));
         cyc(P);
      end
      $display("row %0d data=%h mask=%h dp=%h segs=%h", r, tbl[r].data, tbl[r].mask, tbl[r].dp, e);
   endtask

   initial begin
      int n;
      logic rdy;
      tbl[0] = '{32'h0123ABCD, 8'hFF, 8'h00, 64'h3F065B4F777C395E, 64'h00065B4F777C395E};
      tbl[1] = '{32'h88888888, 8'h0F, 8'h01, 64'h000000007F7F7FFF, 64'h000000007F7F7FFF};
      tbl[2] = '{32'h00000400, 8'hFF, 8'h00, 64'h3F3F3F3F3F663F3F, 64'h0000000000663F3F};
      tbl[3] = '{32'h00000000, 8'hFF, 8'h00, 64'h3F3F3F3F3F3F3F3F, 64'h000000000000003F};
      tbl[4] = '{32'h00000000, 8'hFF, 8'h80, 64'hBF3F3F3F3F3F3F3F, 64'h800000000000003F};
      tbl[5] = '{32'hFEDCBA98, 8'hA5, 8'h0F, 64'h71005E0000F700FF, 64'h71005E0000F700FF};

      ld.load_valid = 1'b0; ld.load_data = '0; ld.load_mask = '0; ld.load_dp = '0;
      cyc(2);
      check("rst_an", 64'(an), 64'd0);
      check("rst_seg", 64'(seg), 64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);
      check("rst_ready", 64'(ld.load_ready), 64'd1);
      nrst   = 1'b1;
      chk_en = 1'b1;

      for (int r = 0; r < 6; r++) run_row(r);

      // Frame period with enable held high.
      wait_fd("fd_first", n);
      wait_fd("fd_second", n);
      check("fd_period", 64'(n), 64'(FRAME));
      $display("frame period %0d cycles", n);

      // Mid-frame load stays in shadow until the wrap.
      cyc(3 * P);
      pulse_load(32'hFFFFFFFF, 8'hFF, 8'h00);
      check("mid_ready_low", 64'(ld.load_ready), 64'd0);
      cyc(2 * P + G - 1);
      check("mid_old_seg", 64'(seg), 64'h5E);
      check("mid_ready_still_low", 64'(ld.load_ready), 64'd0);
      wait_fd("mid_wrap", n);
      check("mid_ready_back", 64'(ld.load_ready), 64'd1);
      cyc(G);
      check("mid_new_d0", 64'(seg), 64'h71);
      cyc(7 * P);
      check("mid_new_d7", 64'(seg), 64'h71);
      $display("mid-frame load 0xFFFFFFFF applied at wrap");

      // Pending load A, then B offered and held until taken right after the wrap.
      pulse_load(32'h11111111, 8'hFF, 8'h00);
      ld.load_valid = 1'b1; ld.load_data = 32'h22222222; ld.load_mask = 8'hFF; ld.load_dp = 8'h00;
      n = 0;
      do begin
         rdy = ld.load_ready;
         cyc(1);
         n++;
      end while (!rdy && n < 2 * FRAME);
      ld.load_valid = 1'b0;
      check("b_accepted", 64'(rdy), 64'd1);
      check("b_pending", 64'(ld.load_ready), 64'd0);
      cyc(G - 1);
      check("a_next_frame", 64'(seg), 64'h06);
      wait_fd("b_wrap", n);
      cyc(G);
      check("b_frame_after", 64'(seg), 64'h5B);
      $display("back-to-back loads A=0x11111111 B=0x22222222 shown in order");

      // Reset during digit 5 with a pending load.
      pulse_load(32'h33333333, 8'hFF, 8'h00);
      cyc(5 * P - 1);
      check("pre_rst_an", 64'(an), 64'h20);
      #2 nrst = 1'b0;
      #1;
      check("in_rst_an", 64'(an), 64'd0);
      check("in_rst_ready", 64'(ld.load_ready), 64'd1);
      cyc(2);
      #2 nrst = 1'b1;
      cyc(1);
      check("post_rst_guard", 64'(an), 64'd0);
      cyc(G);
      check("post_rst_an", 64'(an), 64'h01);
      check("post_rst_seg", 64'(seg), 64'h00);
      $display("reset at digit 5 discarded pending 0x33333333");

      // Enable drop keeps a pending load for the next scan.
      pulse_load(32'h44444444, 8'hFF, 8'h00);
      enable = 1'b0;
      cyc(2);
      check("off_an", 64'(an), 64'd0);
      check("off_seg", 64'(seg), 64'd0);
      check("off_ready", 64'(ld.load_ready), 64'd0);
      enable = 1'b1;
      wait_fd("reenable_wrap", n);
      cyc(G);
      check("pend_kept", 64'(seg), 64'h66);
      $display("pending 0x44444444 survived enable drop");

      // Randomized traffic checked cycle by cycle by the model.
      for (int i = 0; i < 8000; i++) begin
         ld.load_valid = ($urandom_range(0, 19) == 0);
         ld.load_data  = $urandom >> (4 * $urandom_range(0, 8));
         ld.load_mask  = 8'($urandom);
         ld.load_dp    = 8'($urandom);
         if ($urandom_range(0, 399) == 0) enable = 1'b0;
         else if ($urandom_range(0, 9) == 0) enable = 1'b1;
         if ($urandom_range(0, 2999) == 0) begin
            #2 nrst = 1'b0;
            cyc(1);
            #2 nrst = 1'b1;
         end
         cyc(1);
      end
      ld.load_valid = 1'b0;
      $display("random phase done");

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
